// File: rtl/trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_ctrl_pkg
//   Shared constants for the machine-mode trap sequencer: cause codes,
//   privilege encodings, mtvec MODE encoding and the sequencer FSM states.
// -----------------------------------------------------------------------------
package trap_ctrl_pkg;

    // Synchronous exception codes produced by the sequencer itself.
    localparam logic [4:0] EXC_ILLEGAL_INSTR = 5'd2;
    localparam logic [4:0] EXC_ECALL_U       = 5'd8;
    localparam logic [4:0] EXC_ECALL_M       = 5'd11;

    // Machine interrupt codes.
    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    // Privilege levels (only M and U exist on this hart).
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    // mtvec MODE field value that selects vectored interrupt entry.
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_t;

    // mcause layout: interrupt flag in the MSB, code in the low bits.
    function automatic logic [31:0] make_cause(input logic is_irq, input logic [4:0] code);
        return {is_irq, 26'b0, code};
    endfunction

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// trap_prio_enc
//   Combinational request arbiter. Picks the single highest-priority event
//   among EX exception, ECALL, MRET (legal or illegal) and enabled machine
//   interrupts.
// Ports
//   cur_priv, exc_valid, exc_cause, exc_ecall, mret_req    : EX-stage events
//   irq_ext, irq_tmr, irq_sw                               : raw pending lines
//   boundary_ok, mstatus_mie, mie_mask                     : interrupt gating
//   take     : some request is accepted
//   is_irq   : accepted request is an interrupt
//   is_mret  : accepted request is a legal MRET
//   use_tval : mtval comes from exc_tval (otherwise 0)
//   code     : exception / interrupt code
// -----------------------------------------------------------------------------
module trap_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic [1:0] cur_priv,
    input  logic       exc_valid,
    input  logic [4:0] exc_cause,
    input  logic       exc_ecall,
    input  logic       mret_req,
    input  logic       irq_ext,
    input  logic       irq_tmr,
    input  logic       irq_sw,
    input  logic       boundary_ok,
    input  logic       mstatus_mie,
    input  logic [2:0] mie_mask,
    output logic       take,
    output logic       is_irq,
    output logic       is_mret,
    output logic       use_tval,
    output logic [4:0] code
);

    logic [2:0] irq_live;   // {MEI, MTI, MSI}, same order as mie_mask
    logic [4:0] ecall_code;

    assign irq_live   = {irq_ext, irq_tmr, irq_sw} & mie_mask;
    assign ecall_code = (cur_priv == PRIV_U) ? EXC_ECALL_U : EXC_ECALL_M;

    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        take     = 1'b0;
        is_irq   = 1'b0;
        is_mret  = 1'b0;
        use_tval = 1'b0;
        code     = '0;

        if (exc_valid) begin
            take     = 1'b1;
            use_tval = 1'b1;
            code     = exc_cause;
        end else if (exc_ecall) begin
            take = 1'b1;
            code = ecall_code;
        end else if (mret_req) begin
            take = 1'b1;
            // MRET from U-mode is an illegal instruction, not a return.
            if (cur_priv != PRIV_M) begin
                code = EXC_ILLEGAL_INSTR;
            end else begin
                is_mret = 1'b1;
            end
        end else if (mstatus_mie && boundary_ok && (|irq_live)) begin
            take   = 1'b1;
            is_irq = 1'b1;
            // Architectural order: external > software > timer.
            if (irq_live[2]) begin
                code = IRQ_MEI;
            end else if (irq_live[0]) begin
                code = IRQ_MSI;
            end else begin
                code = IRQ_MTI;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Trap / interrupt sequencer in front of the machine-mode CSR file.
//   Accepts one request in IDLE, stalls and flushes the pipeline for
//   FLUSH_CYCLES cycles, emits a one-cycle commit pulse to the CSR file and
//   then hands the redirect PC to fetch over a valid/ready handshake.
// Parameters
//   FLUSH_CYCLES : flush duration before commit (1..15)
//   VECTORED_EN  : honour mtvec MODE=01 for interrupts
// Ports
//   clk, reset                         : clock, async active-high reset
//   cur_priv, exc_*, mret_req          : EX-stage requests
//   irq_ext/irq_tmr/irq_sw             : machine interrupt pending lines
//   boundary_ok, next_pc               : interrupt boundary and its EPC
//   mstatus_mie, mie_mask, mtvec, mepc : CSR file state
//   stall, flush                       : pipeline control
//   trap_commit, mret_commit           : one-cycle CSR update pulses
//   trap_cause, trap_epc, trap_tval    : CSR write data (valid with pulse)
//   redirect_valid/pc/ready            : redirect handshake to fetch
// -----------------------------------------------------------------------------
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter bit          VECTORED_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cur_priv,
    input  logic        exc_valid,
    input  logic [4:0]  exc_cause,
    input  logic        exc_ecall,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_req,
    input  logic        irq_ext,
    input  logic        irq_tmr,
    input  logic        irq_sw,
    input  logic        boundary_ok,
    input  logic [31:0] next_pc,
    input  logic        mstatus_mie,
    input  logic [2:0]  mie_mask,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        stall,
    output logic        flush,
    output logic        trap_commit,
    output logic        mret_commit,
    output logic [31:0] trap_cause,
    output logic [31:0] trap_epc,
    output logic [31:0] trap_tval,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    trap_state_t state;
    logic [3:0]  flush_cnt;

    // Request captured on the IDLE->FLUSH edge.
    logic [31:0] cap_cause;
    logic [31:0] cap_epc;
    logic [31:0] cap_tval;
    logic        cap_is_mret;

    // Arbiter outputs.
    logic       req_take;
    logic       req_is_irq;
    logic       req_is_mret;
    logic       req_use_tval;
    logic [4:0] req_code;

    logic [31:0] mtvec_base;
    logic [31:0] target_pc;

    trap_prio_enc u_prio_enc (
        .cur_priv    (cur_priv),
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause),
        .exc_ecall   (exc_ecall),
        .mret_req    (mret_req),
        .irq_ext     (irq_ext),
        .irq_tmr     (irq_tmr),
        .irq_sw      (irq_sw),
        .boundary_ok (boundary_ok),
        .mstatus_mie (mstatus_mie),
        .mie_mask    (mie_mask),
        .take        (req_take),
        .is_irq      (req_is_irq),
        .is_mret     (req_is_mret),
        .use_tval    (req_use_tval),
        .code        (req_code)
    );

    // Redirect target uses live mtvec/mepc, so it reflects the CSR values
    // present during the COMMIT cycle, when it is registered.
    assign mtvec_base = {mtvec[31:2], 2'b00};

    always_comb begin
        target_pc = mtvec_base;
        if (cap_is_mret) begin
            target_pc = mepc;
        end else if (VECTORED_EN && cap_cause[31] && (mtvec[1:0] == MTVEC_VECTORED)) begin
            target_pc = mtvec_base + {25'b0, cap_cause[4:0], 2'b00};
        end
    end

    // NOTE: state and every output are updated with non-blocking assignments
    // so all registers see pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: capture registers are reset too, not just the FSM, so a
            // reset mid-sequence leaves nothing stale behind.
            state          <= ST_IDLE;
            flush_cnt      <= '0;
            cap_cause      <= '0;
            cap_epc        <= '0;
            cap_tval       <= '0;
            cap_is_mret    <= 1'b0;
            stall          <= 1'b0;
            flush          <= 1'b0;
            trap_commit    <= 1'b0;
            mret_commit    <= 1'b0;
            trap_cause     <= '0;
            trap_epc       <= '0;
            trap_tval      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            // Commit strobes are single-cycle by default.
            trap_commit <= 1'b0;
            mret_commit <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_take) begin
                        state       <= ST_FLUSH;
                        stall       <= 1'b1;
                        flush       <= 1'b1;
                        flush_cnt   <= FLUSH_LOAD;
                        cap_cause   <= make_cause(req_is_irq, req_code);
                        cap_epc     <= req_is_irq ? next_pc : exc_pc;
                        cap_tval    <= req_use_tval ? exc_tval : 32'd0;
                        cap_is_mret <= req_is_mret;
                    end
                end

                ST_FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state       <= ST_COMMIT;
                        flush       <= 1'b0;
                        trap_commit <= ~cap_is_mret;
                        mret_commit <= cap_is_mret;
                        trap_cause  <= cap_cause;
                        trap_epc    <= cap_epc;
                        trap_tval   <= cap_tval;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end

                ST_COMMIT: begin
                    state          <= ST_REDIRECT;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= target_pc;
                end

                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= ST_IDLE;
                        redirect_valid <= 1'b0;
                        stall          <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
